// File: rtl/mem_window_loader_if.sv
// Pixel-stream, memory-port and window-output bundle for mem_window_loader.
// slave: the loader itself; master: whatever drives it and models the memory.
interface mem_window_loader_if #(
  parameter int DW       = 8,
  parameter int MEM_ADDR = 3
);
  logic                start;
  logic [DW-1:0]       pix_in;
  logic                pix_valid;
  logic                pix_ready;
  logic [DW-1:0]       mem_data_in;
  logic [MEM_ADDR-1:0] mem_in_add_row;
  logic [MEM_ADDR-1:0] mem_in_add_col;
  logic                mem_wr_en;
  logic                mem_rd_en;
  logic [MEM_ADDR-1:0] mem_a_add_row;
  logic [MEM_ADDR-1:0] mem_a_add_col;
  logic [3*DW-1:0]     mem_data_out_a;
  logic [3*DW-1:0]     mem_data_out_b;
  logic [3*DW-1:0]     mem_data_out_c;
  logic [3*DW-1:0]     win_a;
  logic [3*DW-1:0]     win_b;
  logic [3*DW-1:0]     win_c;
  logic                win_valid;
  logic                busy;

  modport slave (
    input  start, pix_in, pix_valid, mem_data_out_a, mem_data_out_b, mem_data_out_c,
    output pix_ready, mem_data_in, mem_in_add_row, mem_in_add_col, mem_wr_en,
           mem_rd_en, mem_a_add_row, mem_a_add_col, win_a, win_b, win_c,
           win_valid, busy
  );

  modport master (
    output start, pix_in, pix_valid, mem_data_out_a, mem_data_out_b, mem_data_out_c,
    input  pix_ready, mem_data_in, mem_in_add_row, mem_in_add_col, mem_wr_en,
           mem_rd_en, mem_a_add_row, mem_a_add_col, win_a, win_b, win_c,
           win_valid, busy
  );
endinterface

// File: rtl/mem_window_loader.sv
// Loads a raster-order pixel frame into the pixel memory, then reads the
// 3x3 window centred at (1,1) and presents it with a one-cycle valid pulse.
module mem_window_loader #(
  parameter int DW       = 8,
  parameter int MEM_SIZE = 5,
  parameter int MEM_ADDR = 3
) (
  input logic                clk,
  input logic                reset,
  mem_window_loader_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_READ
  } state_t;

  localparam logic [MEM_ADDR-1:0] LAST   = MEM_ADDR'(MEM_SIZE - 1);
  localparam logic [MEM_ADDR-1:0] CENTRE = MEM_ADDR'(1);

  state_t              state_q, state_d;
  logic [MEM_ADDR-1:0] row_q, row_d;
  logic [MEM_ADDR-1:0] col_q, col_d;
  logic [3*DW-1:0]     win_a_q, win_b_q, win_c_q;
  logic                win_valid_q;

  // State and raster counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Window capture on the closing edge of READ; held until the next READ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_a_q     <= '0;
      win_b_q     <= '0;
      win_c_q     <= '0;
      win_valid_q <= 1'b0;
    end else begin
      win_valid_q <= (state_q == S_READ);
      if (state_q == S_READ) begin
        win_a_q <= bus.mem_data_out_a;
        win_b_q <= bus.mem_data_out_b;
        win_c_q <= bus.mem_data_out_c;
      end
    end
  end

  // Next-state and counter advance.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
          row_d   = '0;
          col_d   = '0;
        end
      end
      S_LOAD: begin
        if (bus.pix_valid) begin
          if (col_q == LAST) begin
            col_d = '0;
            if (row_q == LAST) begin
              state_d = S_READ;
              row_d   = '0;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_READ: state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        row_d   = '0;
        col_d   = '0;
      end
    endcase
  end

  // Memory-port and status outputs decoded from the current state; the write
  // is combinational so it lands on the same edge that accepts the pixel.
  always_comb begin
    bus.pix_ready      = 1'b0;
    bus.mem_wr_en      = 1'b0;
    bus.mem_data_in    = '0;
    bus.mem_in_add_row = row_q;
    bus.mem_in_add_col = col_q;
    bus.mem_rd_en      = 1'b0;
    bus.mem_a_add_row  = '0;
    bus.mem_a_add_col  = '0;
    bus.busy           = 1'b0;
    if (state_q == S_LOAD) begin
      bus.pix_ready   = 1'b1;
      bus.mem_wr_en   = bus.pix_valid;
      bus.mem_data_in = bus.pix_in;
      bus.busy        = 1'b1;
    end else if (state_q == S_READ) begin
      bus.mem_rd_en     = 1'b1;
      bus.mem_a_add_row = CENTRE;
      bus.mem_a_add_col = CENTRE;
      bus.busy          = 1'b1;
    end
  end

  assign bus.win_a     = win_a_q;
  assign bus.win_b     = win_b_q;
  assign bus.win_c     = win_c_q;
  assign bus.win_valid = win_valid_q;

endmodule

// File: tb/tb_mem_window_loader.sv
// Bench for mem_window_loader: behavioural pixel memory, write log, directed
// frame table, reset/idle corner sequences and random frames.
module tb_mem_window_loader;
  localparam int DW = 8;
  localparam int MS = 5;
  localparam int MA = 3;
  localparam int NPIX = MS * MS;

  logic clk = 1'b0;
  logic reset;

  mem_window_loader_if #(.DW(DW), .MEM_ADDR(MA)) bus ();

  mem_window_loader #(.DW(DW), .MEM_SIZE(MS), .MEM_ADDR(MA)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int pulses = 0;

  typedef struct {
    logic [2:0] r;
    logic [2:0] c;
    logic [7:0] d;
  } wr_t;
  wr_t wq[$];

  logic [7:0] mem [MS][MS];
  logic [7:0] frame [NPIX];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural memory: raster writes, 3x3 window read around the given centre.
  always @(posedge clk)
    if (bus.mem_wr_en && bus.mem_in_add_row < MS && bus.mem_in_add_col < MS)
      mem[bus.mem_in_add_row][bus.mem_in_add_col] <= bus.mem_data_in;

  function automatic logic [7:0] mpix(input int r, input int c);
    if (r < 0 || c < 0 || r >= MS || c >= MS) return 8'h5A;
    return mem[r][c];
  endfunction

  function automatic logic [23:0] mrow(input int r, input int c);
    return {mpix(r, c - 1), mpix(r, c), mpix(r, c + 1)};
  endfunction

  always_comb begin
    bus.mem_data_out_a = 24'hA5C3E1;
    bus.mem_data_out_b = 24'hB4D2F0;
    bus.mem_data_out_c = 24'h96877D;
    if (bus.mem_rd_en) begin
      bus.mem_data_out_a = mrow(int'(bus.mem_a_add_row) - 1, int'(bus.mem_a_add_col));
      bus.mem_data_out_b = mrow(int'(bus.mem_a_add_row),     int'(bus.mem_a_add_col));
      bus.mem_data_out_c = mrow(int'(bus.mem_a_add_row) + 1, int'(bus.mem_a_add_col));
    end
  end

  // Every-cycle monitor: port exclusivity, write log, valid pulse count.
  always @(negedge clk) begin
    if (!reset) begin
      n_cmp++;
      if (bus.mem_wr_en && bus.mem_rd_en) begin
        n_fail++;
        $display("FAIL wr_rd_excl: wr_en=%b rd_en=%b required not both 1", bus.mem_wr_en, bus.mem_rd_en);
      end
      if (bus.mem_wr_en) wq.push_back('{r: bus.mem_in_add_row, c: bus.mem_in_add_col, d: bus.mem_data_in});
      if (bus.win_valid) pulses++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] frow(input int r);
    return {frame[r*MS], frame[r*MS+1], frame[r*MS+2]};
  endfunction

  task automatic fill_frame(input int kind);
    for (int i = 0; i < NPIX; i++) begin
      case (kind)
        0:       frame[i] = 8'(i + 1);
        1:       frame[i] = (i == 0 || i == 6 || i == 12) ? 8'hFF : 8'h00;
        default: frame[i] = 8'($urandom);
      endcase
    end
  endtask

  // One full frame: start, stream pixels with the chosen valid pattern, READ, window.
  task automatic run_frame(input int gap, input bit startmid,
                           input logic [23:0] ea, input logic [23:0] eb,
                           input logic [23:0] ec, input int elat);
    int idx;
    int n;
    int p0;
    bit v;
    wq.delete();
    p0 = pulses;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("load_busy", bus.busy, 1);
    idx = 0;
    n = 0;
    while (idx < NPIX && n < 400) begin
      v = (gap == 0) ? 1'b1 : (gap == 1) ? (n % 2 == 0) : 1'($urandom_range(0, 1));
      bus.pix_valid = v;
      bus.pix_in    = v ? frame[idx] : 8'($urandom);
      bus.start     = startmid && (n == 7);
      chk("load_pix_ready", bus.pix_ready, 1);
      tick();
      if (v) idx++;
      n++;
    end
    bus.pix_valid = 1'b0;
    bus.start     = 1'b0;
    chk("load_done", idx, NPIX);
    chk("read_rd_en", bus.mem_rd_en, 1);
    chk("read_wr_en", bus.mem_wr_en, 0);
    chk("read_a_row", bus.mem_a_add_row, 1);
    chk("read_a_col", bus.mem_a_add_col, 1);
    chk("read_pix_ready", bus.pix_ready, 0);
    chk("read_busy", bus.busy, 1);
    chk("read_win_valid", bus.win_valid, 0);
    tick();
    chk("win_valid", bus.win_valid, 1);
    chk("win_a", bus.win_a, ea);
    chk("win_b", bus.win_b, eb);
    chk("win_c", bus.win_c, ec);
    chk("idle_busy", bus.busy, 0);
    chk("idle_rd_en", bus.mem_rd_en, 0);
    if (elat != 0) chk("latency", n + 1, elat);
    tick();
    chk("win_valid_drop", bus.win_valid, 0);
    chk("win_a_hold", bus.win_a, ea);
    chk("pulse_count", pulses - p0, 1);
    chk("wr_count", wq.size(), NPIX);
    for (int i = 0; i < NPIX && i < wq.size(); i++) begin
      chk("wr_row", wq[i].r, i / MS);
      chk("wr_col", wq[i].c, i % MS);
      chk("wr_data", wq[i].d, frame[i]);
    end
  endtask

  typedef struct {
    int          kind;
    int          gap;
    bit          startmid;
    logic [23:0] a;
    logic [23:0] b;
    logic [23:0] c;
    int          lat;
  } vec_t;
  vec_t vt[4];

  initial begin
    vt[0] = '{kind: 0, gap: 0, startmid: 1'b0, a: 24'h010203, b: 24'h060708, c: 24'h0B0C0D, lat: 26};
    vt[1] = '{kind: 0, gap: 1, startmid: 1'b0, a: 24'h010203, b: 24'h060708, c: 24'h0B0C0D, lat: 50};
    vt[2] = '{kind: 1, gap: 0, startmid: 1'b0, a: 24'hFF0000, b: 24'h00FF00, c: 24'h0000FF, lat: 26};
    vt[3] = '{kind: 0, gap: 0, startmid: 1'b1, a: 24'h010203, b: 24'h060708, c: 24'h0B0C0D, lat: 26};

    reset = 1'b1;
    bus.start = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_in = '0;
    tick();
    tick();
    chk("rst_win_a", bus.win_a, 0);
    chk("rst_win_b", bus.win_b, 0);
    chk("rst_win_c", bus.win_c, 0);
    chk("rst_win_valid", bus.win_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_pix_ready", bus.pix_ready, 0);
    chk("rst_wr_en", bus.mem_wr_en, 0);
    chk("rst_rd_en", bus.mem_rd_en, 0);
    chk("rst_addrs", {bus.mem_a_add_row, bus.mem_a_add_col, bus.mem_in_add_row, bus.mem_in_add_col}, 0);
    chk("rst_data_in", bus.mem_data_in, 0);
    reset = 1'b0;
    tick();

    // pix_valid in IDLE must be ignored.
    wq.delete();
    bus.pix_valid = 1'b1;
    bus.pix_in = 8'h55;
    for (int i = 0; i < 3; i++) begin
      chk("idle_pix_ready", bus.pix_ready, 0);
      chk("idle_wr_en", bus.mem_wr_en, 0);
      tick();
    end
    chk("idle_no_writes", wq.size(), 0);
    bus.pix_valid = 1'b0;

    for (int t = 0; t < 4; t++) begin
      fill_frame(vt[t].kind);
      run_frame(vt[t].gap, vt[t].startmid, vt[t].a, vt[t].b, vt[t].c, vt[t].lat);
    end

    // Reset partway through LOAD: outputs clear asynchronously, next frame is clean.
    fill_frame(0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.pix_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.pix_in = frame[i];
      tick();
    end
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_pix_ready", bus.pix_ready, 0);
    chk("arst_wr_en", bus.mem_wr_en, 0);
    chk("arst_in_row", bus.mem_in_add_row, 0);
    chk("arst_win_a", bus.win_a, 0);
    chk("arst_win_b", bus.win_b, 0);
    bus.pix_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    fill_frame(2);
    run_frame(0, 1'b0, frow(0), frow(1), frow(2), 26);

    // Random frames with random valid gaps and occasional start during LOAD.
    for (int k = 0; k < 5; k++) begin
      fill_frame(2);
      run_frame(2, 1'($urandom_range(0, 1)), frow(0), frow(1), frow(2), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_window_loader.md
Name: mem_window_loader

Overview:
Write-side sequencer and window reader for the 5x5 signed pixel memory used by the CNN datapath.
- Accepts a raster-order pixel stream over a valid/ready handshake and drives the memory write port (data, row/col address, wr_en).
- After the last pixel is written, switches the memory to read mode and reads the 3x3 window centred at (1,1).
- Registers the three returned row words and presents them to the convolution stage with a one-cycle valid pulse.

Parameters:
DW, 8, pixel width in bits (signed two's complement)
MEM_SIZE, 5, frame edge length; frame holds MEM_SIZE*MEM_SIZE pixels
MEM_ADDR, 3, row/col address width; must satisfy 2**MEM_ADDR >= MEM_SIZE

Ports:
clk  in  1  system clock; all state changes on the rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  begin a frame load; sampled only in IDLE
pix_in  in  DW  signed pixel data
pix_valid  in  1  pix_in is valid this cycle
pix_ready  out  1  loader accepts a pixel this cycle
mem_data_in  out  DW  memory write data
mem_in_add_row  out  MEM_ADDR  memory write row address
mem_in_add_col  out  MEM_ADDR  memory write column address
mem_wr_en  out  1  memory write enable
mem_rd_en  out  1  memory window-read enable
mem_a_add_row  out  MEM_ADDR  window centre row
mem_a_add_col  out  MEM_ADDR  window centre column
mem_data_out_a  in  3*DW  memory window top row, {left, centre, right}
mem_data_out_b  in  3*DW  memory window middle row
mem_data_out_c  in  3*DW  memory window bottom row
win_a  out  3*DW  registered top row
win_b  out  3*DW  registered middle row
win_c  out  3*DW  registered bottom row
win_valid  out  1  one-cycle pulse: win_a/b/c updated
busy  out  1  high in LOAD and READ

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port named reset.
- Reset values:
  - State IDLE; row/col counters 0.
  - win_a/b/c = 0; win_valid = 0; busy = 0; pix_ready = 0.
  - mem_wr_en = 0; mem_rd_en = 0.
  - mem_a_add_row/col = 0; mem_in_add_row/col = 0; mem_data_in = 0.
- States: IDLE, LOAD, READ.
- IDLE:
  - pix_ready = 0; pix_valid is ignored and no memory write occurs.
  - start = 1 -> LOAD next cycle, with row = col = 0.
- LOAD:
  - pix_ready = 1.
  - mem_wr_en = pix_valid, combinational, so the write lands at the same edge that accepts the pixel (zero latency).
  - mem_data_in = pix_in; mem_in_add_row = row counter; mem_in_add_col = col counter.
  - On each accepted pixel:
    - col < MEM_SIZE-1: col increments.
    - col = MEM_SIZE-1: col wraps to 0 and row increments.
  - Accept at row = col = MEM_SIZE-1 -> READ, with counters cleared to 0.
  - Cycles with pix_valid = 0 hold the counters and perform no write.
  - start is ignored during LOAD.
- READ (exactly one cycle):
  - mem_rd_en = 1, mem_wr_en = 0, mem_a_add_row = mem_a_add_col = 1, pix_ready = 0.
  - At the closing edge, win_a/b/c capture mem_data_out_a/b/c and win_valid = 1 for one cycle.
  - State returns to IDLE.
  - The last LOAD write has already landed, so the window reflects the full frame.
- Outside READ, mem_rd_en = 0 and mem_a_add_row/col = 0. mem_wr_en and mem_rd_en are never high together.
- win_a/b/c hold their values until the next READ or reset.
- busy = 1 in LOAD and READ.
- Back-to-back frames: start may be asserted in the cycle win_valid is high (state is IDLE). Minimum frame period is MEM_SIZE*MEM_SIZE + 2 cycles.
- Reset mid-LOAD or mid-READ:
  - Immediate return to reset values; the partial frame is abandoned.
  - Memory contents are not cleared by this block.
- Signed data is passed through bit-exact; no arithmetic is applied.

Test Plan:
- Reset, then start, then pixels 1..25 with pix_valid held high -> 25 writes with addresses (0,0)..(4,4) in raster order. One READ cycle follows, then win_a = 24'h010203, win_b = 24'h060708, win_c = 24'h0B0C0D, win_valid high for exactly 1 cycle, busy low afterwards.
- Same frame with pix_valid low on every other cycle -> no writes on idle cycles, identical window values, win_valid asserted 50 cycles after the first pixel.
- Pixels -1 (8'hFF) at positions (0,0),(1,1),(2,2), all others 0 -> win_a = 24'hFF0000, win_b = 24'h00FF00, win_c = 24'h0000FF.
- reset asserted after 10 pixels accepted -> outputs return to 0 asynchronously. A new start plus 25 pixels gives the correct window, with the first write at address (0,0).
- pix_valid high in IDLE, and start pulsed during LOAD -> pix_ready = 0 and no write in IDLE; the counters are unaffected by the start during LOAD.
- Check on every cycle -> mem_wr_en and mem_rd_en are never both 1.
